// File: rtl/segdecode_pkg.sv
// Shared frame layout and FSM encoding for the segment/keypad link (host and slave).
// Pure declarations; no timing or flow control of its own.
package segdecode_pkg;

    localparam int FRAME_BITS = 8;
    localparam int COL_MSB    = 7;
    localparam int ROW_MSB    = 5;
    localparam int DIGIT_MSB  = 3;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_SHIFT  = 3'd2;
    localparam state_t ST_SETTLE = 3'd3;
    localparam state_t ST_SAMPLE = 3'd4;
    localparam state_t ST_GAP    = 3'd5;

    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [1:0] col,
        input logic [1:0] row,
        input logic [3:0] digit
    );
        logic [FRAME_BITS-1:0] f;
        f                  = '0;
        f[COL_MSB -: 2]    = col;
        f[ROW_MSB -: 2]    = row;
        f[DIGIT_MSB -: 4]  = digit;
        return f;
    endfunction

endpackage

// File: rtl/segdecode_host_sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset to 0.
// Latency: 2 clk; no backpressure.
module segdecode_host_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/segdecode_host.sv
// Host SPI master/scanner: streams 16 {col,row,digit} frames per scan, reads keys back on MISO.
// Frame = 1+8+SETTLE+1+GAP cycles; key_state/key_valid one cycle after frame 15; no backpressure, run sampled per scan.
module segdecode_host
    import segdecode_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int GAP_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] digits,
    output logic        en,
    output logic        mosi,
    input  logic        miso,
    output logic [15:0] key_state,
    output logic        key_valid,
    output logic        busy
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);

    state_t                state_q, state_d;
    logic [2:0]            bit_q, bit_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [3:0]            idx_q, idx_d;
    logic [15:0]           snap_q, snap_d;
    logic [FRAME_BITS-1:0] sh_q, sh_d;
    logic [15:0]           stage_q, stage_d;
    logic [15:0]           key_state_q, key_state_d;
    logic                  key_valid_q, key_valid_d;
    logic                  en_q, en_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;

    logic                  miso_s;
    logic [1:0]            row, col;
    logic [3:0]            digit_sel;
    logic                  end_of_frame;

    segdecode_host_sync2 u_miso_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (miso),
        .q     (miso_s)
    );

    assign row       = idx_q[1:0];
    assign col       = idx_q[3:2];
    assign digit_sel = snap_q[{row, 2'b00} +: 4];

    always_comb begin
        state_d      = state_q;
        bit_d        = bit_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        sh_d         = sh_q;
        stage_d      = stage_q;
        key_state_d  = key_state_q;
        key_valid_d  = 1'b0;
        end_of_frame = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_LOAD;
                    snap_d  = digits;
                end
            end
            ST_LOAD: begin
                sh_d    = pack_frame(col, row, digit_sel);
                bit_d   = 3'd0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sh_d  = {sh_q[FRAME_BITS-2:0], 1'b0};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LAST;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                stage_d[{row, col}] = miso_s;
                if (GAP_CYCLES == 0) begin
                    end_of_frame = 1'b1;
                end else begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LAST;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    end_of_frame = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Scan boundary: publish staged keys and decide whether to keep scanning.
        if (end_of_frame) begin
            idx_d = idx_q + 4'd1;
            if (idx_q == 4'd15) begin
                key_state_d = stage_d;
                key_valid_d = 1'b1;
                if (run) begin
                    state_d = ST_LOAD;
                    snap_d  = digits;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                state_d = ST_LOAD;
            end
        end

        // Outputs are decoded from the next state so they are registered yet aligned with it.
        en_d   = (state_d == ST_SHIFT);
        mosi_d = en_d & sh_d[FRAME_BITS-1];
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            bit_q       <= 3'd0;
            cnt_q       <= 8'd0;
            idx_q       <= 4'd0;
            snap_q      <= 16'd0;
            sh_q        <= '0;
            stage_q     <= 16'd0;
            key_state_q <= 16'd0;
            key_valid_q <= 1'b0;
            en_q        <= 1'b0;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            sh_q        <= sh_d;
            stage_q     <= stage_d;
            key_state_q <= key_state_d;
            key_valid_q <= key_valid_d;
            en_q        <= en_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
        end
    end

    assign en        = en_q;
    assign mosi      = mosi_q;
    assign key_state = key_state_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_segdecode_host.sv
// Bench for segdecode_host: default instance plus a SETTLE=2/GAP=0 instance, each with a keypad slave model.
module tb_segdecode_host;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        run0, run1;
    logic [15:0] dig0, dig1, keys0, keys1;
    logic        en0, mosi0, miso0, kv0, busy0;
    logic        en1, mosi1, miso1, kv1, busy1;
    logic [15:0] ks0, ks1;

    int total = 0;
    int bad   = 0;

    segdecode_host u_dut0 (
        .clk(clk), .rst_n(rst_n), .run(run0), .digits(dig0), .en(en0), .mosi(mosi0),
        .miso(miso0), .key_state(ks0), .key_valid(kv0), .busy(busy0)
    );

    segdecode_host #(.SETTLE_CYCLES(2), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .run(run1), .digits(dig1), .en(en1), .mosi(mosi1),
        .miso(miso1), .key_state(ks1), .key_valid(kv1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame i carries column i/4, row i%4 and the digit shown on that row.
    function automatic logic [7:0] exp_frame(input int i, input logic [15:0] d);
        int row;
        int col;
        row = i % 4;
        col = i / 4;
        return 8'((col << 6) + (row << 4) + ((int'(d) >> (4 * row)) & 15));
    endfunction

    // Slave models: shift on EN high, latch when EN drops after a full byte; MISO = key of latched row/col.
    logic [7:0]  sh0 = '0, lat0 = '0, sh1 = '0, lat1 = '0;
    logic [15:0] msnap0 = '0, msnap1 = '0;
    logic [7:0]  cap0 [16];
    bit          cap_en0 = 1'b0;
    int cnt0 = 0, fidx0 = 0, nfull0 = 0, badlen0 = 0, lowrun0 = 0, gap0 = 0, enrise0 = 0, mosibad0 = 0;
    int cnt1 = 0, fidx1 = 0, nfull1 = 0, badlen1 = 0, lowrun1 = 0, gap1 = 0, enrise1 = 0, mosibad1 = 0;

    assign miso0 = keys0[{lat0[5:4], lat0[7:6]}];
    assign miso1 = keys1[{lat1[5:4], lat1[7:6]}];

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt0    <= 0;
            fidx0   <= 0;
            lowrun0 <= 0;
        end else if (en0) begin
            if (cnt0 == 0) begin
                gap0    <= lowrun0;
                enrise0 <= enrise0 + 1;
            end
            sh0  <= {sh0[6:0], mosi0};
            cnt0 <= cnt0 + 1;
        end else begin
            if (mosi0) mosibad0 <= mosibad0 + 1;
            if (cnt0 == 8) begin
                lat0 <= sh0;
                check("frame0", sh0, exp_frame(fidx0, (fidx0 == 0) ? dig0 : msnap0));
                if (fidx0 == 0) msnap0 <= dig0;
                if (cap_en0) cap0[fidx0] <= sh0;
                fidx0  <= (fidx0 + 1) % 16;
                nfull0 <= nfull0 + 1;
            end else if (cnt0 != 0) begin
                badlen0 <= badlen0 + 1;
            end
            lowrun0 <= (cnt0 != 0) ? 1 : lowrun0 + 1;
            cnt0    <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt1    <= 0;
            fidx1   <= 0;
            lowrun1 <= 0;
        end else if (en1) begin
            if (cnt1 == 0) begin
                gap1    <= lowrun1;
                enrise1 <= enrise1 + 1;
            end
            sh1  <= {sh1[6:0], mosi1};
            cnt1 <= cnt1 + 1;
        end else begin
            if (mosi1) mosibad1 <= mosibad1 + 1;
            if (cnt1 == 8) begin
                lat1 <= sh1;
                check("frame1", sh1, exp_frame(fidx1, (fidx1 == 0) ? dig1 : msnap1));
                if (fidx1 == 0) msnap1 <= dig1;
                fidx1  <= (fidx1 + 1) % 16;
                nfull1 <= nfull1 + 1;
            end else if (cnt1 != 0) begin
                badlen1 <= badlen1 + 1;
            end
            lowrun1 <= (cnt1 != 0) ? 1 : lowrun1 + 1;
            cnt1    <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_kv0(input int limit, output int n);
        n = 0;
        while (!kv0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_kv1(input int limit, output int n);
        n = 0;
        while (!kv1 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_idle0(input int limit);
        int n;
        n = 0;
        while (busy0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle0_reached", busy0, 1'b0);
    endtask

    localparam int FRAME0 = 1 + 8 + 4 + 1 + 8;
    localparam int SCAN0  = 16 * FRAME0;
    localparam int FRAME1 = 1 + 8 + 2 + 1 + 0;
    localparam int SCAN1  = 16 * FRAME1;

    initial begin
        int n;
        int nf;
        int er;
        logic [15:0] r;

        rst_n = 1'b0;
        run0  = 1'b1;
        run1  = 1'b0;
        dig0  = 16'hA5C3;
        dig1  = 16'h1234;
        keys0 = 16'(1 << (4 * 2 + 1));
        keys1 = 16'h0000;

        tick(3);
        check("rst_en", en0, 1'b0);
        check("rst_mosi", mosi0, 1'b0);
        check("rst_keys", ks0, 16'h0000);
        check("rst_kv", kv0, 1'b0);
        check("rst_busy", busy0, 1'b0);

        @(negedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        check("load_en", en0, 1'b0);
        check("load_busy", busy0, 1'b1);
        cap_en0 = 1'b1;
        tick(1);
        check("en_rise", en0, 1'b1);

        wait_kv0(2 * SCAN0, n);
        check("scan_len", n + 1, SCAN0);
        check("keys_dir", ks0, keys0);
        check("busy_run", busy0, 1'b1);
        cap_en0 = 1'b0;
        check("frm_0", cap0[0], 8'h03);
        check("frm_1", cap0[1], 8'h1C);
        check("frm_5", cap0[5], 8'h5C);
        check("frm_15", cap0[15], 8'hFA);
        nf = nfull0;
        tick(1);
        check("kv_pulse", kv0, 1'b0);

        // Drop run and change digits inside frame 7 of the second scan.
        tick(7 * FRAME0 + 5 - 1);
        run0 = 1'b0;
        dig0 = 16'h0F0F;
        wait_kv0(2 * SCAN0, n);
        check("drop_kv", n, SCAN0 - (7 * FRAME0 + 5));
        check("drop_keys", ks0, keys0);
        check("drop_busy", busy0, 1'b0);
        check("drop_frames", nfull0 - nf, 16);
        er = enrise0;
        tick(60);
        check("drop_quiet", enrise0, er);
        check("drop_idle", busy0, 1'b0);

        // Reset during bit 4 of frame 3.
        keys0 = 16'h8001;
        run0  = 1'b1;
        tick(1);
        check("r2_busy", busy0, 1'b1);
        tick(3 * FRAME0 + 1 + 4);
        check("pre_rst_en", en0, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", en0, 1'b0);
        check("mid_rst_mosi", mosi0, 1'b0);
        check("mid_rst_busy", busy0, 1'b0);
        check("mid_rst_keys", ks0, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        check("rst_restart_busy", busy0, 1'b1);
        wait_kv0(2 * SCAN0, n);
        check("rst_restart_len", n, SCAN0);
        check("rst_restart_keys", ks0, keys0);
        run0 = 1'b0;
        wait_idle0(2 * SCAN0);

        for (int it = 0; it < 4; it++) begin
            r     = 16'($urandom);
            dig0  = r;
            r     = 16'($urandom);
            keys0 = r;
            run0  = 1'b1;
            tick(1);
            run0 = 1'b0;
            wait_kv0(2 * SCAN0, n);
            check("rand_len", n, SCAN0);
            check("rand_keys", ks0, keys0);
            tick(1);
            check("rand_idle", busy0, 1'b0);
            check("rand_kv_low", kv0, 1'b0);
        end
        check("gap_dflt", gap0, 4 + 1 + 8 + 1);

        // Zero-gap instance: back-to-back scans.
        r     = 16'($urandom);
        dig1  = r;
        r     = 16'($urandom);
        keys1 = r;
        run1  = 1'b1;
        tick(1);
        check("g0_busy", busy1, 1'b1);
        wait_kv1(2 * SCAN1, n);
        check("g0_len", n, SCAN1);
        check("g0_keys", ks1, keys1);
        check("g0_gap", gap1, 2 + 1 + 1);
        r     = 16'($urandom);
        keys1 = r;
        run1  = 1'b0;
        tick(1);
        wait_kv1(2 * SCAN1, n);
        check("g0_len2", n + 1, SCAN1);
        check("g0_keys2", ks1, keys1);
        tick(1);
        check("g0_idle", busy1, 1'b0);
        check("g0_kv_low", kv1, 1'b0);
        check("g0_frames", nfull1, 32);

        check("len_bad0", badlen0, 0);
        check("len_bad1", badlen1, 0);
        check("mosi_idle0", mosibad0, 0);
        check("mosi_idle1", mosibad1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
